// File: rtl/xd_event_sched_pkg.sv
// rtl/xd_event_sched_pkg.sv - shared FSM type, gap timer width and tag width helper for the event scheduler
package xd_sched_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, HOLD} sched_state_t;

  localparam int GAP_W = 8;

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xd_event_sched_if.sv
// rtl/xd_event_sched_if.sv - requester/launch bundle; XD_EVENT_SCHED_STATS_EN adds launch/drop statistics
interface xd_event_sched_if #(
  parameter int N_REQ = 4
);
  import xd_sched_pkg::*;

  localparam int TAG_W = tag_w(N_REQ);

  logic [N_REQ-1:0] req_i;
  logic             clr_ovf_i;
  logic             pulse_o;
  logic [TAG_W-1:0] tag_o;
  logic [N_REQ-1:0] pend_o;
  logic [N_REQ-1:0] ovf_o;
  logic             busy_o;

`ifdef XD_EVENT_SCHED_STATS_EN
  logic [15:0] launch_cnt_o;
  logic [15:0] drop_cnt_o;

  modport master (
    output req_i, clr_ovf_i,
    input  pulse_o, tag_o, pend_o, ovf_o, busy_o, launch_cnt_o, drop_cnt_o
  );
  modport slave (
    input  req_i, clr_ovf_i,
    output pulse_o, tag_o, pend_o, ovf_o, busy_o, launch_cnt_o, drop_cnt_o
  );
`else
  modport master (
    output req_i, clr_ovf_i,
    input  pulse_o, tag_o, pend_o, ovf_o, busy_o
  );
  modport slave (
    input  req_i, clr_ovf_i,
    output pulse_o, tag_o, pend_o, ovf_o, busy_o
  );
`endif

endinterface

// File: rtl/xd_event_sched_rr_pick.sv
// rtl/xd_event_sched_rr_pick.sv - combinational round-robin picker; search starts at ptr_i and wraps
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_o,
  output logic             vld_o
);

  // Scan from the farthest offset down so the nearest request to ptr_i is written last.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = IDX_W'((int'(ptr_i) + i) % N);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xd_event_sched.sv
// rtl/xd_event_sched.sv - merges requester event pulses onto one GAP-spaced pulse/tag CDC channel
// Optional statistics outputs are built when XD_EVENT_SCHED_STATS_EN is defined.
module xd_event_sched
  import xd_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 3,
  parameter int GAP   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  xd_event_sched_if.slave    bus
);

  localparam int               TAG_W    = tag_w(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 2);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] ovf_q, ovf_d, drop, dec_v, nz;
  logic [TAG_W-1:0] ptr_q, ptr_d, win_q, win_d, tag_q, tag_d, gnt_idx;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pulse_q, pulse_d, busy_q, busy_d, gnt_vld;

  always_comb begin
    for (int r = 0; r < N_REQ; r++) nz[r] = (cnt_q[r] != '0);
  end

  rr_pick #(.N(N_REQ), .IDX_W(TAG_W)) u_rr_pick (
    .req_i (nz),
    .ptr_i (ptr_q),
    .gnt_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    gap_d   = gap_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          win_d   = gnt_idx;
          tag_d   = gnt_idx;
          pulse_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        ptr_d   = (win_q == TAG_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        gap_d   = GAP_LOAD;
        state_d = (GAP_LOAD == '0) ? IDLE : HOLD;
      end
      HOLD: begin
        // HOLD lasts GAP-2 cycles; with LAUNCH and IDLE the spacing is exactly GAP.
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dec_v = '0;
    if (state_q == LAUNCH) dec_v[win_q] = 1'b1;
    drop   = '0;
    busy_d = (state_d != IDLE);
    for (int r = 0; r < N_REQ; r++) begin
      cnt_d[r] = cnt_q[r];
      if (dec_v[r] && !bus.req_i[r]) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end else if (bus.req_i[r] && !dec_v[r]) begin
        if (cnt_q[r] == CNT_MAX) drop[r] = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + 1'b1;
      end
      if (cnt_d[r] != '0) busy_d = 1'b1;
    end
    // A fresh overflow beats a same-cycle clear.
    ovf_d = (bus.clr_ovf_i ? '0 : ovf_q) | drop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '{default: '0};
      ovf_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      tag_q   <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      tag_q   <= tag_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.pulse_o = pulse_q;
  assign bus.tag_o   = tag_q;
  assign bus.pend_o  = nz;
  assign bus.ovf_o   = ovf_q;
  assign bus.busy_o  = busy_q;

`ifdef XD_EVENT_SCHED_STATS_EN
  logic [15:0] launch_cnt_q, launch_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [16:0] drop_sum;

  always_comb begin
    launch_cnt_d = launch_cnt_q + ((state_q == LAUNCH) ? 16'd1 : 16'd0);
    drop_sum     = {1'b0, drop_cnt_q} + 17'($countones(drop));
    drop_cnt_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      launch_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      launch_cnt_q <= launch_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.launch_cnt_o = launch_cnt_q;
  assign bus.drop_cnt_o   = drop_cnt_q;
`endif

endmodule
